// File: rtl/rate_sequencer_pkg.sv
// Shared types and default sizing for the rate sequencer.
// entry_t is the table record at the default hold width.
package rate_sequencer_pkg;

    localparam int unsigned DEF_STEPS  = 4;
    localparam int unsigned DEF_HOLD_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    typedef struct packed {
        logic [3:0]            shift;
        logic [DEF_HOLD_W-1:0] hold;
    } entry_t;

endpackage

// File: rtl/rate_valley_detect.sv
// Valley detector: arms on the first non-zero sample while enabled and pulses
// valley_o when an armed detector sees the sample return to zero.
module rate_valley_detect (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [15:0] tri_i,
    output logic        valley_o
);

    logic armed_d, armed_q;

    assign valley_o = enable_i && armed_q && (tri_i == 16'd0);

    always_comb begin
        armed_d = armed_q;
        if (!enable_i || valley_o) begin
            armed_d = 1'b0;
        end else if (tri_i != 16'd0) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/rate_sequencer.sv
// Rate sequencer: walks a triangle generator through a programmed table of
// (shift_by, hold) entries, moving on after each entry's count of valleys.
module rate_sequencer
    import rate_sequencer_pkg::*;
#(
    parameter int unsigned STEPS  = DEF_STEPS,
    parameter int unsigned HOLD_W = DEF_HOLD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [3:0]               wr_shift,
    input  logic [HOLD_W-1:0]        wr_hold,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [15:0]              tri_in,
    output logic [3:0]               shift_by,
    output logic                     gen_reset,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned   SW        = $clog2(STEPS);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    typedef struct packed {
        logic [3:0]        shift;
        logic [HOLD_W-1:0] hold;
    } tab_entry_t;

    tab_entry_t        tab_d [STEPS];
    tab_entry_t        tab_q [STEPS];
    state_e            state_d, state_q;
    logic [SW-1:0]     step_d, step_q;
    logic [3:0]        shift_d, shift_q;
    logic [HOLD_W-1:0] hold_d, hold_q;
    logic              gen_reset_d, gen_reset_q;
    logic              done_d, done_q;
    logic              valley;

    // A stop in RUN also disarms, so a coincident valley is never counted.
    rate_valley_detect u_valley (
        .clk_i    (clk),
        .reset_i  (reset),
        .enable_i ((state_q == StRun) && !stop),
        .tri_i    (tri_in),
        .valley_o (valley)
    );

    always_comb begin
        for (int i = 0; i < STEPS; i++) begin
            tab_d[i] = tab_q[i];
        end
        if (wr_en) begin
            tab_d[wr_addr] = '{shift: wr_shift, hold: wr_hold};
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        gen_reset_d = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StLoad;
                    step_d  = '0;
                end
            end
            StLoad: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    shift_d     = tab_q[step_q].shift;
                    gen_reset_d = 1'b1;
                    hold_d      = (tab_q[step_q].hold == '0) ? HOLD_W'(1) : tab_q[step_q].hold;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (valley) begin
                    if (hold_q > HOLD_W'(1)) begin
                        hold_d = hold_q - 1'b1;
                    end else begin
                        hold_d = '0;
                        if (step_q != LAST_STEP) begin
                            step_d  = step_q + 1'b1;
                            state_d = StLoad;
                        end else if (loop) begin
                            step_d  = '0;
                            state_d = StLoad;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                tab_q[i] <= '{shift: 4'd0, hold: HOLD_W'(1)};
            end
            state_q     <= StIdle;
            step_q      <= '0;
            shift_q     <= 4'd0;
            hold_q      <= '0;
            gen_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            for (int i = 0; i < STEPS; i++) begin
                tab_q[i] <= tab_d[i];
            end
            state_q     <= state_d;
            step_q      <= step_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            gen_reset_q <= gen_reset_d;
            done_q      <= done_d;
        end
    end

    assign shift_by  = shift_q;
    assign gen_reset = gen_reset_q;
    assign step      = step_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_rate_sequencer.sv
// Scoreboard bench for rate_sequencer: a modelled triangle generator feeds the
// DUT, expected (step, shift, valley count) segments are queued per run.
module tb_rate_sequencer;
    import rate_sequencer_pkg::*;

    localparam int STEPS  = DEF_STEPS;
    localparam int HOLD_W = DEF_HOLD_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_addr = '0;
    logic [3:0]        wr_shift = '0;
    logic [HOLD_W-1:0] wr_hold = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop = 1'b0;
    logic [15:0]       tri_in = '0;
    logic [3:0]        shift_by;
    logic              gen_reset;
    logic [1:0]        step;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    rate_sequencer #(.STEPS(STEPS), .HOLD_W(HOLD_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_shift  (wr_shift),
        .wr_hold   (wr_hold),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .tri_in    (tri_in),
        .shift_by  (shift_by),
        .gen_reset (gen_reset),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        bit is_done;
        int stp;
        int shift;
        int hold;
    } exp_t;

    exp_t   exp_q[$];
    entry_t model_tab[STEPS];
    int     total = 0;
    int     bad = 0;

    // Monitor-owned view of the currently presented segment.
    bit seg_open = 0;
    int seg_cnt = 0;
    int seg_hold = 0;
    int seg_shift = 0;
    bit seen_nz = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Triangle generator model: restarts at 0 on gen_reset, random peaks and
    // random extra zero dwell at each valley.
    initial begin
        int  v = 0;
        int  peak = 1;
        int  dwell = 0;
        bit  rising = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_reset) begin
                v = 0;
                rising = 1;
                dwell = 0;
                peak = int'($urandom_range(1, 4));
            end else if (rising) begin
                v++;
                if (v >= peak) rising = 0;
            end else if (v > 0) begin
                v--;
                if (v == 0) dwell = int'($urandom_range(0, 2));
            end else if (dwell > 0) begin
                dwell--;
            end else begin
                peak = int'($urandom_range(1, 4));
                v = 1;
                rising = (v < peak);
            end
            tri_in = 16'(v * 613);
        end
    end

    // Monitor: pops an expectation whenever the DUT presents a new segment
    // (busy with gen_reset) or a done pulse.
    initial begin
        exp_t e;
        bit   prev_gr = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seg_open = 0;
                prev_gr = 0;
            end else begin
                if (busy && gen_reset) begin
                    if (seg_open) check("valley count", seg_cnt, seg_hold);
                    seg_open = 0;
                    check("gen_reset one cycle", int'(prev_gr), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected segment", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("segment kind", 0, int'(e.is_done));
                        check("segment step", int'(step), e.stp);
                        check("segment shift", int'(shift_by), e.shift);
                        seg_open = 1;
                        seg_cnt = 0;
                        seg_hold = e.hold;
                        seg_shift = e.shift;
                        seen_nz = 0;
                    end
                end else if (seg_open && busy) begin
                    check("shift stable", int'(shift_by), seg_shift);
                    if (tri_in != 16'd0) begin
                        seen_nz = 1;
                    end else if (seen_nz) begin
                        seg_cnt++;
                        seen_nz = 0;
                    end
                end
                if (done) begin
                    if (seg_open) check("valley count", seg_cnt, seg_hold);
                    seg_open = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done expected", int'(e.is_done), 1);
                    end
                end else if (!busy) begin
                    seg_open = 0;
                end
                prev_gr = gen_reset;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_entry(input int a, input int s, input int h);
        wr_en = 1'b1;
        wr_addr = 2'(a);
        wr_shift = 4'(s);
        wr_hold = HOLD_W'(h);
        tick();
        wr_en = 1'b0;
        model_tab[a].shift = 4'(s);
        model_tab[a].hold = HOLD_W'(h);
    endtask

    task automatic push_pass();
        exp_t e;
        for (int i = 0; i < STEPS; i++) begin
            e.is_done = 0;
            e.stp = i;
            e.shift = int'(model_tab[i].shift);
            e.hold = (model_tab[i].hold == '0) ? 1 : int'(model_tab[i].hold);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_run(input bit lp);
        exp_t e;
        push_pass();
        if (!lp) begin
            e.is_done = 1;
            e.stp = 0;
            e.shift = 0;
            e.hold = 0;
            exp_q.push_back(e);
        end
        loop = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check({name, " finished"}, int'(busy), 0);
        tick();
        check({name, " leftover expects"}, exp_q.size(), 0);
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check({name, " drained"}, exp_q.size(), 0);
    endtask

    task automatic do_stop(input string name);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check({name, " busy after stop"}, int'(busy), 0);
        check({name, " done after stop"}, int'(done), 0);
        tick();
        check({name, " no late done"}, int'(done), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " step"}, int'(step), 0);
        check({name, " shift_by"}, int'(shift_by), 0);
        check({name, " gen_reset"}, int'(gen_reset), 1);
        check({name, " busy"}, int'(busy), 0);
        check({name, " done"}, int'(done), 0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < STEPS; i++) begin
            model_tab[i].shift = 4'd0;
            model_tab[i].hold = HOLD_W'(1);
        end
    endtask

    task automatic load_ref_table();
        write_entry(0, 2, 3);
        write_entry(1, 5, 1);
        write_entry(2, 0, 2);
        write_entry(3, 7, 1);
    endtask

    initial begin
        int n;
        bit hit;
        reset_model();

        reset = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();
        check("gen_reset falls after reset", int'(gen_reset), 0);

        // Default table: four shift=0, hold=1 segments then done.
        start_run(0);
        wait_idle("default table");

        load_ref_table();
        start_run(0);
        wait_idle("reference run");

        // Looping run: wrap to step 0 with shift 2, rewrite entry 1 mid-step.
        start_run(1);
        n = 0;
        while (!(busy && gen_reset && step == 2'd1) && n < 3000) begin
            tick();
            n++;
        end
        check("reached step 1", int'(step), 1);
        write_entry(1, 9, 2);
        wait_drained("loop pass 1");
        push_pass();
        wait_drained("loop pass 2");
        do_stop("loop stop");

        // A write in the LOAD cycle must not affect that LOAD; hold=0 acts as 1.
        load_ref_table();
        write_entry(2, 4, 0);
        start_run(0);
        write_entry(0, 11, 2);
        wait_idle("load-cycle write");
        start_run(0);
        wait_idle("after load-cycle write");

        // Stop coincident with the last valley of step 1.
        load_ref_table();
        write_entry(1, 5, 2);
        start_run(0);
        n = 0;
        hit = 0;
        while (!hit && n < 3000) begin
            tick();
            n++;
            if (busy && !gen_reset && step == 2'd1 && seg_open && seg_cnt == 1 &&
                seen_nz && tri_in == 16'd0) begin
                stop = 1'b1;
                hit = 1;
            end
        end
        check("found final valley of step 1", int'(hit), 1);
        tick();
        stop = 1'b0;
        check("stop+valley busy", int'(busy), 0);
        check("stop+valley step", int'(step), 1);
        check("stop+valley shift held", int'(shift_by), 5);
        check("stop+valley done", int'(done), 0);
        tick();
        check("stop+valley no late done", int'(done), 0);
        exp_q.delete();

        // Reset mid-RUN, then a fresh start from step 0 with a reset table.
        start_run(1);
        repeat ($urandom_range(8, 30)) tick();
        reset = 1'b1;
        tick();
        check_reset_vals("reset mid-run");
        reset = 1'b0;
        exp_q.delete();
        reset_model();
        tick();
        start_run(0);
        wait_idle("restart after reset");

        // Randomised runs with random tables, loop mode and aborts.
        for (int it = 0; it < 6; it++) begin
            bit lp;
            lp = 1'($urandom_range(0, 1));
            for (int i = 0; i < STEPS; i++) begin
                write_entry(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            end
            start_run(lp);
            if (lp) begin
                wait_drained("random loop pass 1");
                push_pass();
                repeat ($urandom_range(1, 40)) tick();
                if (busy) do_stop("random loop");
                else check("random loop still busy", int'(busy), 1);
            end else if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 40)) tick();
                if (busy) do_stop("random abort");
                else wait_idle("random short run");
            end else begin
                wait_idle("random run");
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
